// File: rtl/mips_pkg.sv
// Shared types and constants for the sequencer and the decoder.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_sequencer_if.sv
// Memory/decoder-side signals of the sequencer, bundled for port connection.
interface mips_sequencer_if
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic             waitrequest;
  logic [31:0]      readdata;
  logic             halt_req;
  logic             extra;
  logic             branch_taken;
  state_t           state;
  logic [31:0]      instruction;
  logic             active;
  logic             delay_slot;
  logic             retire;
  logic [CNT_W-1:0] instr_count;

  // Environment side: memory and decoder drive the inputs, observe the outputs.
  modport master (
    output waitrequest, readdata, halt_req, extra, branch_taken,
    input  state, instruction, active, delay_slot, retire, instr_count
  );

  // Sequencer side.
  modport slave (
    input  waitrequest, readdata, halt_req, extra, branch_taken,
    output state, instruction, active, delay_slot, retire, instr_count
  );

endinterface

// File: rtl/mips_instr_reg.sv
// Instruction register with load enable and optional byte reversal.
module mips_instr_reg
  import mips_pkg::*;
#(
  parameter int unsigned BYTE_SWAP = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  output logic [31:0] ir_o
);

  logic [31:0] ir_q;
  logic [31:0] ir_d;

  // Select raw or byte-reversed fetch word.
  always_comb begin
    ir_d = data_i;
    if (BYTE_SWAP != 0) begin
      ir_d = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
    end
  end

  // IR holds until the next completed fetch; resets to NOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= NOP;
    end else if (load_i) begin
      ir_q <= ir_d;
    end
  end

  assign ir_o = ir_q;

endmodule

// File: rtl/mips_sequencer.sv
// FETCH/EXEC1/EXEC2/HALT control sequencer: owns IR, delay-slot tracking
// and the retired-instruction counter.
module mips_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned BYTE_SWAP = 0,
  parameter int unsigned CNT_W     = 32
) (
  input logic             clk,
  input logic             reset_n,
  mips_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             ds_q, ds_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ir_load;
  logic             retire;
  logic             exec1_exit;

  // Next-state decode; retire is combinational from state/waitrequest/extra.
  always_comb begin
    state_d    = state_q;
    ir_load    = 1'b0;
    retire     = 1'b0;
    exec1_exit = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (!bus.waitrequest) begin
          state_d = EXEC1;
          ir_load = 1'b1;
        end
      end
      EXEC1: begin
        if (!bus.waitrequest) begin
          exec1_exit = 1'b1;
          if (bus.extra) begin
            state_d = EXEC2;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      EXEC2: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  // Delay-slot bookkeeping and retire counter.
  always_comb begin
    pend_d = pend_q;
    ds_d   = ds_q;
    if (ir_load && pend_q) begin
      ds_d = 1'b1;
    end
    if (retire && ds_q) begin
      ds_d   = 1'b0;
      pend_d = 1'b0;
    end
    // Applied last so a new branch set beats a same-cycle clear; a branch
    // inside a delay slot is ignored and never re-arms.
    if (exec1_exit && bus.branch_taken && !ds_q) begin
      pend_d = 1'b1;
    end
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, delay-slot and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pend_q  <= 1'b0;
      ds_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ds_q    <= ds_d;
      cnt_q   <= cnt_d;
    end
  end

  mips_instr_reg #(
    .BYTE_SWAP(BYTE_SWAP)
  ) u_ir (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (ir_load),
    .data_i (bus.readdata),
    .ir_o   (bus.instruction)
  );

  assign bus.state       = state_q;
  assign bus.active      = (state_q != HALT);
  assign bus.delay_slot  = ds_q;
  assign bus.retire      = retire;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_mips_sequencer.sv
// Self-checking bench: two sequencers (plain/32-bit counter and
// byte-swapped/4-bit counter) on shared stimulus, against a behavioural model.
module tb_mips_sequencer;

  logic clk;
  logic reset_n;

  mips_sequencer_if #(.CNT_W(32)) bus_a ();
  mips_sequencer_if #(.CNT_W(4))  bus_b ();

  mips_sequencer #(.BYTE_SWAP(0), .CNT_W(32)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  mips_sequencer #(.BYTE_SWAP(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Shared input drive for both DUTs.
  task automatic drive(input bit wr, input logic [31:0] rd, input bit hr, input bit ex, input bit br);
    bus_a.waitrequest = wr;  bus_b.waitrequest = wr;
    bus_a.readdata = rd;     bus_b.readdata = rd;
    bus_a.halt_req = hr;     bus_b.halt_req = hr;
    bus_a.extra = ex;        bus_b.extra = ex;
    bus_a.branch_taken = br; bus_b.branch_taken = br;
  endtask

  // One clock: drive inputs, sample state/retire mid-cycle, finish just after the edge.
  task automatic step(input bit wr, input logic [31:0] rd, input bit hr, input bit ex, input bit br,
                      output logic [1:0] st, output logic ret);
    drive(wr, rd, hr, ex, br);
    @(negedge clk);
    st  = bus_a.state;
    ret = bus_a.retire;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Behavioural model: phase 0 fetch,1 first exec,2 second exec,3 halted.
  int unsigned m_ph;
  logic [31:0] m_word;
  int unsigned m_retired;
  bit          m_pend, m_ds;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0; m_word <= '0; m_retired <= 0; m_pend <= 1'b0; m_ds <= 1'b0;
    end else begin
      if (m_ph == 0) begin
        if (bus_a.halt_req) m_ph <= 3;
        else if (!bus_a.waitrequest) begin
          m_word <= bus_a.readdata;
          m_ph   <= 1;
          if (m_pend) m_ds <= 1'b1;
        end
      end else if (m_ph == 1) begin
        if (!bus_a.waitrequest) begin
          if (bus_a.branch_taken && !m_ds) m_pend <= 1'b1;
          if (bus_a.extra) m_ph <= 2;
          else begin
            m_ph <= 0;
            m_retired <= m_retired + 1;
            if (m_ds) begin m_ds <= 1'b0; m_pend <= 1'b0; end
          end
        end
      end else if (m_ph == 2) begin
        m_ph <= 0;
        m_retired <= m_retired + 1;
        if (m_ds) begin m_ds <= 1'b0; m_pend <= 1'b0; end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_ret;
      exp_ret = (m_ph == 2) || (m_ph == 1 && !bus_a.waitrequest && !bus_a.extra);
      chk("state_a", 32'(bus_a.state), m_ph);
      chk("state_b", 32'(bus_b.state), m_ph);
      chk("ir_a", bus_a.instruction, m_word);
      chk("ir_b", bus_b.instruction, swap32(m_word));
      chk("active", {30'd0, bus_b.active, bus_a.active}, (m_ph != 3) ? 32'd3 : 32'd0);
      chk("ds", {30'd0, bus_b.delay_slot, bus_a.delay_slot}, m_ds ? 32'd3 : 32'd0);
      chk("retire", {30'd0, bus_b.retire, bus_a.retire}, exp_ret ? 32'd3 : 32'd0);
      chk("cnt_a", bus_a.instr_count, m_retired);
      chk("cnt_b", 32'(bus_b.instr_count), m_retired % 16);
    end
  end

  logic [1:0]  st;
  logic        ret;
  logic [1:0]  st_seq [6];
  logic        ret_seq[6];

  initial begin
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus_a.state), 32'd0);
    chk("rst_active", 32'(bus_a.active), 32'd1);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Fetch with 3 wait cycles, then a 2-cycle instruction.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, st, ret);
    step(1'b0, 32'h2408_0005, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t2_exec1", 32'(bus_a.state), 32'd1);
    chk("t2_ir_a", bus_a.instruction, 32'h2408_0005);
    chk("t2_ir_b", bus_b.instruction, 32'h0500_0824);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t2_retire", 32'(ret), 32'd1);
    chk("t2_cnt", bus_a.instr_count, 32'd1);

    // Load: EXEC1 stalls two cycles, then EXEC2.
    step(1'b0, 32'h8C82_0004, 1'b0, 1'b1, 1'b0, st_seq[0], ret_seq[0]);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, st_seq[1], ret_seq[1]);
    step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, st_seq[2], ret_seq[2]);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, st_seq[3], ret_seq[3]);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st_seq[4], ret_seq[4]);
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, st_seq[5], ret_seq[5]);
    chk("t3_seq", {20'd0, st_seq[0], st_seq[1], st_seq[2], st_seq[3], st_seq[4], st_seq[5]},
        {20'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0});
    chk("t3_ret", {26'd0, ret_seq[0], ret_seq[1], ret_seq[2], ret_seq[3], ret_seq[4], ret_seq[5]},
        32'b000010);
    chk("t3_cnt", bus_a.instr_count, 32'd2);

    // Asynchronous reset in the middle of an EXEC1 stall.
    step(1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, st, ret);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1_state", 32'(bus_a.state), 32'd0);
    chk("t1_ir", bus_a.instruction, 32'd0);
    chk("t1_cnt", bus_a.instr_count, 32'd0);
    chk("t1_active", 32'(bus_a.active), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Branch, delay-slot instruction (with an ignored branch), then a plain one.
    step(1'b0, 32'h1000_0004, 1'b0, 1'b0, 1'b0, st, ret);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, st, ret);
    chk("t5_ds_fetch", 32'(bus_a.delay_slot), 32'd0);
    step(1'b0, 32'h2409_0001, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t5_ds_exec1", 32'(bus_a.delay_slot), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, st, ret);
    chk("t5_ds_exec2", 32'(bus_a.delay_slot), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t5_ds_after", 32'(bus_a.delay_slot), 32'd0);
    step(1'b0, 32'h240A_0002, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t5_ds_next", 32'(bus_a.delay_slot), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t5_cnt", bus_a.instr_count, 32'd3);

    // 17 retires: 4-bit counter wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, st, ret);
      step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, st, ret);
    end
    chk("t6_cnt_b", 32'(bus_b.instr_count), 32'd1);
    chk("t6_cnt_a", bus_a.instr_count, 32'd17);
    step(1'b0, 32'h0500_0824, 1'b0, 1'b0, 1'b0, st, ret);
    chk("t6_swap_b", bus_b.instruction, 32'h2408_0005);
    chk("t6_swap_a", bus_a.instruction, 32'h0500_0824);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st, ret);

    // Randomised traffic with occasional halts and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 299) do_reset();
      else step(($urandom % 3) == 0, $urandom, ($urandom % 80) == 0,
                1'($urandom), 1'($urandom), st, ret);
    end

    // Halt requested together with a ready memory; HALT is sticky.
    do_reset();
    step(1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, st, ret);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, st, ret);
    step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, st, ret);
    chk("t4_state", 32'(bus_a.state), 32'd3);
    chk("t4_active", 32'(bus_a.active), 32'd0);
    chk("t4_ir", bus_a.instruction, 32'hA5A5_0001);
    for (int i = 0; i < 10; i++)
      step(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), st, ret);
    chk("t4_state_hold", 32'(bus_a.state), 32'd3);
    chk("t4_ir_hold", bus_a.instruction, 32'hA5A5_0001);
    chk("t4_cnt_hold", bus_a.instr_count, 32'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
